// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing for the stopwatch control slice.
package stopwatch_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] LAP   = 2'd2;
    localparam logic [1:0] PAUSE = 2'd3;

    localparam int unsigned DEFAULT_DIV   = 10_000_000;
    localparam int unsigned DEFAULT_DIV_W = 24;

endpackage

// File: rtl/sw_prescaler.sv
// Decisecond prescaler: counts while enabled, pulses tick on the terminal count and wraps.
module sw_prescaler
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV   = DEFAULT_DIV,
    parameter int unsigned DIV_W = DEFAULT_DIV_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Holding when disabled keeps the sub-tick phase across a pause.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for the BCD stopwatch datapath.
// Optional auto-stop at 9:59.9 is enabled by defining AUTO_STOP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV   = DEFAULT_DIV,
    parameter int unsigned DIV_W = DEFAULT_DIV_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ss_btn,
    input  logic       lr_btn,
    input  logic       at_max,
    output logic       tick,
    output logic       sw_clr,
    output logic       disp_hold,
    output logic [1:0] state,
    output logic       done
);

    logic [1:0] state_q, state_d;
    logic       ss_q, lr_q;
    logic       sw_clr_q, clr_d;
    logic       done_q, done_d;
    logic       ss_edge, lr_edge;
    logic       run_en, pre_tick, auto_stop;

    assign ss_edge = ss_btn & ~ss_q;
    // Start/stop has priority: a coincident lap/reset edge is discarded.
    assign lr_edge = lr_btn & ~lr_q & ~ss_edge;
    assign run_en  = (state_q == RUN) || (state_q == LAP);

    sw_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_en),
        .clr   (clr_d),
        .tick  (pre_tick)
    );

`ifdef AUTO_STOP_EN
    assign auto_stop = pre_tick & at_max;
`else
    logic unused_at_max;
    assign unused_at_max = at_max;
    assign auto_stop     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sw_clr_q <= 1'b0;
            done_q   <= 1'b0;
            ss_q     <= 1'b0;
            lr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sw_clr_q <= clr_d;
            done_q   <= done_d;
            ss_q     <= ss_btn;
            lr_q     <= lr_btn;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        done_d  = done_q;
        if (auto_stop) begin
            state_d = PAUSE;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_edge) begin
                        state_d = RUN;
                    end else if (lr_edge) begin
                        clr_d = 1'b1;
                    end
                end
                RUN: begin
                    if (ss_edge) begin
                        state_d = PAUSE;
                    end else if (lr_edge) begin
                        state_d = LAP;
                    end
                end
                LAP: begin
                    if (ss_edge) begin
                        state_d = PAUSE;
                    end else if (lr_edge) begin
                        state_d = RUN;
                    end
                end
                PAUSE: begin
                    // After an auto-stop only a clear may leave PAUSE.
                    if (ss_edge && !done_q) begin
                        state_d = RUN;
                    end else if (lr_edge) begin
                        state_d = IDLE;
                        clr_d   = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        disp_hold = (state_q == LAP);
        tick      = pre_tick & ~auto_stop;
        sw_clr    = sw_clr_q;
        done      = done_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DIV=4): directed steps plus random buttons vs a model.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_PAUSE = 3;
`ifdef AUTO_STOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss_btn = 1'b0;
    logic       lr_btn = 1'b0;
    logic       at_max = 1'b0;
    logic       tick, sw_clr, disp_hold, done;
    logic [1:0] state;

    stopwatch_ctrl #(
        .DIV   (DIV),
        .DIV_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ss_btn    (ss_btn),
        .lr_btn    (lr_btn),
        .at_max    (at_max),
        .tick      (tick),
        .sw_clr    (sw_clr),
        .disp_hold (disp_hold),
        .state     (state),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: mode, sub-tick phase, pending clear pulse, sticky done, button history.
    int m_st = S_IDLE;
    int m_ph = 0;
    bit m_clr = 1'b0;
    bit m_done = 1'b0;
    bit m_ssq = 1'b0;
    bit m_lrq = 1'b0;
    bit last_tick = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_ph = 0; m_clr = 1'b0; m_done = 1'b0; m_ssq = 1'b0; m_lrq = 1'b0;
    endtask

    task automatic step();
        bit on, wrap, stop, ss_e, lr_e, n_clr, n_done;
        int n_st, n_ph;
        @(negedge clk);
        on   = (m_st == S_RUN) || (m_st == S_LAP);
        wrap = on && (m_ph == DIV - 1);
        stop = AUTO && wrap && at_max;
        last_tick = tick;
        chk("state", {30'b0, state}, m_st);
        chk("tick", {31'b0, tick}, {31'b0, wrap && !stop});
        chk("sw_clr", {31'b0, sw_clr}, {31'b0, m_clr});
        chk("disp_hold", {31'b0, disp_hold}, {31'b0, m_st == S_LAP});
        chk("done", {31'b0, done}, {31'b0, m_done});
        ss_e   = ss_btn && !m_ssq;
        lr_e   = lr_btn && !m_lrq && !ss_e;
        n_st   = m_st;
        n_ph   = on ? (m_ph + 1) % DIV : m_ph;
        n_clr  = 1'b0;
        n_done = m_done;
        if (stop) begin
            n_st = S_PAUSE; n_done = 1'b1;
        end else if (m_st == S_IDLE) begin
            if (ss_e) n_st = S_RUN;
            else if (lr_e) n_clr = 1'b1;
        end else if (m_st == S_RUN) begin
            if (ss_e) n_st = S_PAUSE;
            else if (lr_e) n_st = S_LAP;
        end else if (m_st == S_LAP) begin
            if (ss_e) n_st = S_PAUSE;
            else if (lr_e) n_st = S_RUN;
        end else begin
            if (ss_e && !m_done) n_st = S_RUN;
            else if (lr_e) begin
                n_st = S_IDLE; n_clr = 1'b1; n_done = 1'b0;
            end
        end
        if (n_clr) n_ph = 0;
        @(posedge clk);
        m_st = n_st; m_ph = n_ph; m_clr = n_clr; m_done = n_done;
        m_ssq = ss_btn; m_lrq = lr_btn;
        #1;
    endtask

    task automatic press_ss();
        ss_btn = 1'b1; step(); ss_btn = 1'b0;
    endtask

    task automatic press_lr();
        lr_btn = 1'b1; step(); lr_btn = 1'b0;
    endtask

    // Cycles up to and including the next tick; 21 means none within the budget.
    task automatic wait_tick(output int n);
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (last_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_ticks(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (last_tick) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {30'b0, state}, S_IDLE);
        chk("rst_tick", {31'b0, tick}, 0);
        chk("rst_sw_clr", {31'b0, sw_clr}, 0);
        chk("rst_disp_hold", {31'b0, disp_hold}, 0);
        chk("rst_done", {31'b0, done}, 0);
        rst_n = 1'b1;
        model_reset();
        step();

        // 1: start, first tick after DIV cycles, then every DIV cycles
        press_ss();
        chk("t1_run", {30'b0, state}, S_RUN);
        wait_tick(n);
        chk("t1_first_tick", n, DIV);
        wait_tick(n);
        chk("t1_period", n, DIV);

        // Asynchronous reset mid-run
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", {30'b0, state}, S_IDLE);
        chk("arst_tick", {31'b0, tick}, 0);
        chk("arst_sw_clr", {31'b0, sw_clr}, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_hold_tick", {31'b0, tick}, 0);
        rst_n = 1'b1;
        step();

        // 2: lap freeze and release
        press_ss();
        press_lr();
        chk("t2_lap", {30'b0, state}, S_LAP);
        chk("t2_hold", {31'b0, disp_hold}, 1);
        count_ticks(6, cnt);
        chk("t2_lap_ticks", {31'b0, cnt > 0}, 1);
        press_lr();
        chk("t2_run", {30'b0, state}, S_RUN);
        chk("t2_unhold", {31'b0, disp_hold}, 0);

        // 3: pause two cycles into the period, resume keeps phase
        wait_tick(n);
        chk("t3_sync", {31'b0, n <= DIV}, 1);
        step();
        press_ss();
        chk("t3_pause", {30'b0, state}, S_PAUSE);
        count_ticks(20, cnt);
        chk("t3_no_tick", cnt, 0);
        press_ss();
        chk("t3_resume", {30'b0, state}, S_RUN);
        wait_tick(n);
        chk("t3_resume_tick", n, 2);

        // 4: clear from PAUSE and from IDLE
        press_ss();
        press_lr();
        chk("t4_clr_on", {31'b0, sw_clr}, 1);
        chk("t4_idle", {30'b0, state}, S_IDLE);
        step();
        chk("t4_clr_off", {31'b0, sw_clr}, 0);
        press_lr();
        chk("t4_idle_clr_on", {31'b0, sw_clr}, 1);
        step();
        chk("t4_idle_clr_off", {31'b0, sw_clr}, 0);
        press_ss();
        wait_tick(n);
        chk("t4_cleared_phase", n, DIV);

        // 5: simultaneous edges, then a held button
        ss_btn = 1'b1;
        lr_btn = 1'b1;
        step();
        chk("t5_ss_wins", {30'b0, state}, S_PAUSE);
        repeat (9) step();
        chk("t5_held_both", {30'b0, state}, S_PAUSE);
        ss_btn = 1'b0;
        lr_btn = 1'b0;
        step();
        ss_btn = 1'b1;
        repeat (10) step();
        chk("t5_held_ss", {30'b0, state}, S_RUN);
        ss_btn = 1'b0;
        step();

        // 6: at_max behaviour
        at_max = 1'b1;
        if (AUTO) begin
            cnt = 0;
            for (int i = 0; i < 10 && state != 2'(S_PAUSE); i++) begin
                step();
                if (last_tick) cnt++;
            end
            chk("t6_stop", {30'b0, state}, S_PAUSE);
            chk("t6_no_tick", cnt, 0);
            chk("t6_done", {31'b0, done}, 1);
            press_ss();
            step();
            chk("t6_ss_ignored", {30'b0, state}, S_PAUSE);
            press_lr();
            chk("t6_exit", {30'b0, state}, S_IDLE);
            chk("t6_done_clr", {31'b0, done}, 0);
        end else begin
            count_ticks(8, cnt);
            chk("t6_wrap_ticks", cnt, 2);
            chk("t6_no_done", {31'b0, done}, 0);
        end
        at_max = 1'b0;

        // Random button and at_max activity against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) ss_btn = ~ss_btn;
            if ($urandom_range(0, 3) == 0) lr_btn = ~lr_btn;
            at_max = ($urandom_range(0, 7) == 0);
            step();
        end
        ss_btn = 1'b0;
        lr_btn = 1'b0;
        at_max = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
